// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO slice: default sizing,
// the address-width helper and the accepted-operation encoding.
package fifo_pkg;

  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Operation actually accepted in a cycle, after full/empty qualification
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2,
    OP_RW   = 2'd3
  } fifo_op_e;

  // Number of address bits needed to index a storage array of 'depth' words
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: synchronous write port and a
// registered read port. Reset clears only the read data register; the
// array contents survive reset.
module fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the word at the write address when a write is accepted
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: register the addressed word on an accepted read, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync_buffer.sv
// Single-clock synchronous FIFO with registered read data, full/empty
// flags, occupancy count and sticky overflow/underflow flags.
// Optional almost_full/almost_empty outputs are enabled by defining
// the macro FIFO_ALMOST_FLAGS_EN.
module fifo_sync_buffer
  import fifo_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                    almost_full,
  output logic                    almost_empty
`endif
);

  localparam int AW = addr_w(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          wr_acc;
  logic          rd_acc;
  fifo_op_e      op;

  // The extra MSB on each pointer is a wrap bit: equal pointers mean empty,
  // equal addresses with differing wrap bits mean full.
  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_addr == rd_addr);
  assign count   = wr_ptr - rd_ptr;

  // A write into a full FIFO is still taken when a read frees a slot the same
  // cycle; reads never bypass, so a read of an empty FIFO is always refused.
  assign wr_acc  = wr_en && (!full || rd_en);
  assign rd_acc  = rd_en && !empty;

  // Classify the accepted operation for the pointer update
  always_comb begin
    op = OP_IDLE;
    case ({wr_acc, rd_acc})
      2'b10:   op = OP_WR;
      2'b01:   op = OP_RD;
      2'b11:   op = OP_RW;
      default: op = OP_IDLE;
    endcase
  end

  // Advance the pointers for each accepted operation
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      case (op)
        OP_WR: wr_ptr <= wr_ptr + PW'(1);
        OP_RD: rd_ptr <= rd_ptr + PW'(1);
        OP_RW: begin
          wr_ptr <= wr_ptr + PW'(1);
          rd_ptr <= rd_ptr + PW'(1);
        end
        default: begin
          wr_ptr <= wr_ptr;
          rd_ptr <= rd_ptr;
        end
      endcase
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef FIFO_ALMOST_FLAGS_EN
  // Threshold flags follow the pointer-derived count
  assign almost_full  = (count >= PW'(AF_LEVEL));
  assign almost_empty = (count <= PW'(AE_LEVEL));
`endif

endmodule

// File: tb/tb_fifo_sync_buffer.sv
// Self-checking bench for fifo_sync_buffer. The stimulus process steps a
// queue-based reference model and pushes the expected post-edge state into
// a scoreboard; a monitor process pops and compares after each clock edge.
// Also exercises almost_full/almost_empty when FIFO_ALMOST_FLAGS_EN is set.
module tb_fifo_sync_buffer;
  import fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  fifo_sync_buffer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] rd_data;
    int            count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_rd;
  logic          model_ovf;
  logic          model_unf;
  int            cyc_n;
  int            total;
  int            bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it, and report any difference
  task automatic checkOutput(input int cyc, input string name,
                             input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL cyc=%0d %s got=%0h want=%0h", cyc, name, got, want);
    end
  endtask

  // Drive one cycle of inputs, step the reference model, queue the expectation
  task automatic applyStimulus(input logic r, input logic w, input logic [DW-1:0] d,
                               input logic rd);
    exp_t e;
    bit   was_full;
    bit   was_empty;
    @(negedge clk);
    rst     = r;
    wr_en   = w;
    wr_data = d;
    rd_en   = rd;
    if (r) begin
      model_q.delete();
      model_rd  = '0;
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (w && was_full && !rd) model_ovf = 1'b1;
      if (rd && was_empty) model_unf = 1'b1;
      if (rd && !was_empty) model_rd = model_q.pop_front();
      if (w && (!was_full || rd)) model_q.push_back(d);
    end
    cyc_n++;
    e.cyc     = cyc_n;
    e.rd_data = model_rd;
    e.count   = model_q.size();
    e.full    = (model_q.size() == DEPTH);
    e.empty   = (model_q.size() == 0);
    e.ovf     = model_ovf;
    e.unf     = model_unf;
    exp_q.push_back(e);
  endtask

  // Monitor: after each active edge, compare the DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e.cyc, "rd_data",   32'(rd_data),   32'(e.rd_data));
        checkOutput(e.cyc, "count",     32'(count),     32'(e.count));
        checkOutput(e.cyc, "full",      32'(full),      32'(e.full));
        checkOutput(e.cyc, "empty",     32'(empty),     32'(e.empty));
        checkOutput(e.cyc, "overflow",  32'(overflow),  32'(e.ovf));
        checkOutput(e.cyc, "underflow", 32'(underflow), 32'(e.unf));
`ifdef FIFO_ALMOST_FLAGS_EN
        checkOutput(e.cyc, "almost_full",  32'(almost_full),  32'(e.count >= DEPTH - 2));
        checkOutput(e.cyc, "almost_empty", 32'(almost_empty), 32'(e.count <= 1));
`endif
      end
    end
  end

  initial begin
    logic [DW-1:0] x;
    fifo_op_e      op;
    total     = 0;
    bad       = 0;
    cyc_n     = 0;
    model_rd  = '0;
    model_ovf = 1'b0;
    model_unf = 1'b0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    wr_data   = '0;

    $display("[TB] reset and fill to full");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, DW'(i), 1'b0);

    $display("[TB] drain in order");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    $display("[TB] overflow and underflow");
    for (int i = 0; i < 28; i++) applyStimulus(1'b0, 1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 28; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    $display("[TB] read after write");
    for (int i = 0; i < 25; i++) begin
      x = (i == 0) ? 8'h04 : DW'($urandom);
      applyStimulus(1'b0, 1'b1, x, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    end

    $display("[TB] simultaneous read and write");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, DW'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, DW'(i + 8'h30), 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      op = fifo_op_e'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 99) == 0), (op == OP_WR || op == OP_RW),
                    DW'($urandom), (op == OP_RD || op == OP_RW));
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
